// File: rtl/axi_lite_regfile_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile_slave
//   AXI4-Lite completer backed by NUM_REGS word registers starting at
//   BASE_ADDR. Write and read channels run independent two-state FSMs; AW and
//   W may arrive in either order or together. Out-of-range accesses complete
//   with SLVERR and leave the bank untouched.
//
//   Handshake rule on every channel: a transfer happens on the rising aclk
//   edge where valid and ready are both high; a source holds valid and its
//   payload stable until that edge, and ready never depends on valid.
//
// Ports
//   aclk, areset_n          clock, asynchronous active-low reset
//   awaddr/awvalid/awready  write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready     write response channel
//   araddr/arvalid/arready  read address channel
//   rdata/rresp/rvalid/rready read data channel
//
// Optional build macro
//   AXIL_RO_ID_REG_EN : register NUM_REGS-1 becomes a read-only ID register
//                       reading 32'hA11E_0001; writes to it return SLVERR.
//
// FSM state is held in w_state_q / r_state_q for hierarchical observation.
// -----------------------------------------------------------------------------
module axi_lite_regfile_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    aclk,
   input  logic                    areset_n,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rvalid,
   input  logic                    rready
);

   localparam int         IDX_W  = $clog2(NUM_REGS);
   localparam int         STRB_W = DATA_WIDTH / 8;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;

   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  aw_have_q, aw_have_d;
   logic                  w_have_q, w_have_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   logic aw_fire, w_fire, ar_fire;
   assign aw_fire = awvalid & awready_q;
   assign w_fire  = wvalid  & wready_q;
   assign ar_fire = arvalid & arready_q;

   // The commit uses whichever copy of each half is current: the live bus
   // value when it is handshaking this cycle, otherwise the captured one.
   logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
   logic [DATA_WIDTH-1:0] wr_data, rd_value;
   logic [STRB_W-1:0]     wr_strb;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic                  wr_hit, wr_ok, rd_hit;

   assign wr_addr = aw_fire ? awaddr : awaddr_q;
   assign wr_data = w_fire ? wdata : wdata_q;
   assign wr_strb = w_fire ? wstrb : wstrb_q;

   // BASE_ADDR is aligned to the bank size, so a hit is simply "offset has no
   // bits above the word index".
   assign wr_off = wr_addr - BASE_ADDR;
   assign wr_hit = (wr_addr >= BASE_ADDR) && (wr_off[ADDR_WIDTH-1:IDX_W+2] == '0);
   assign wr_idx = wr_off[IDX_W+1:2];
   assign rd_off = araddr - BASE_ADDR;
   assign rd_hit = (araddr >= BASE_ADDR) && (rd_off[ADDR_WIDTH-1:IDX_W+2] == '0);
   assign rd_idx = rd_off[IDX_W+1:2];

   // Byte offset within a word is ignored.
   logic [3:0] unused_off_bits;
   assign unused_off_bits = {wr_off[1:0], rd_off[1:0]};

`ifdef AXIL_RO_ID_REG_EN
   assign wr_ok    = wr_hit && (wr_idx != IDX_W'(NUM_REGS - 1));
   assign rd_value = (rd_idx == IDX_W'(NUM_REGS - 1)) ? DATA_WIDTH'(32'hA11E_0001)
                                                     : regs_q[rd_idx];
`else
   assign wr_ok    = wr_hit;
   assign rd_value = regs_q[rd_idx];
`endif

   // Write channel
   always_comb begin
      w_state_d = w_state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      aw_have_d = aw_have_q;
      w_have_d  = w_have_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      regs_d    = regs_q;
      case (w_state_q)
         W_IDLE: begin
            if (aw_fire) begin
               aw_have_d = 1'b1;
               awaddr_d  = awaddr;
            end
            if (w_fire) begin
               w_have_d = 1'b1;
               wdata_d  = wdata;
               wstrb_d  = wstrb;
            end
            if ((aw_have_q | aw_fire) && (w_have_q | w_fire)) begin
               aw_have_d = 1'b0;
               w_have_d  = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               bvalid_d  = 1'b1;
               bresp_d   = wr_ok ? OKAY : SLVERR;
               w_state_d = W_RESP;
               if (wr_ok) begin
                  for (int b = 0; b < STRB_W; b++) begin
                     if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                  end
               end
            end else begin
               // Also raises both readies on the first edge out of reset.
               awready_d = !(aw_have_q | aw_fire);
               wready_d  = !(w_have_q | w_fire);
            end
         end
         W_RESP: begin
            if (bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = W_IDLE;
            end
         end
      endcase
   end

   // Read channel; regs_q is the pre-write value when a write commits on
   // the same edge.
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (ar_fire) begin
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rdata_d   = rd_hit ? rd_value : '0;
               rresp_d   = rd_hit ? OKAY : SLVERR;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         aw_have_q <= 1'b0;
         w_have_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         regs_q    <= '{default: '0};
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         aw_have_q <= aw_have_d;
         w_have_q  <= w_have_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         regs_q    <= regs_d;
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_regfile_slave
//   Directed and randomized AXI4-Lite traffic against axi_lite_regfile_slave.
//   A transaction-level model (register array plus response queues) predicts
//   every output on every cycle; directed sequences also pin literal values.
//   Honours AXIL_RO_ID_REG_EN when defined.
// -----------------------------------------------------------------------------
module tb_axi_lite_regfile_slave;

   localparam int          NUM_REGS = 16;
   localparam logic [31:0] BASE     = 32'h0000_0000;

   // ---------------- clock / reset ----------------
   logic        aclk = 1'b0;
   logic        areset_n;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   always #5 aclk = ~aclk;

   axi_lite_regfile_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE)
   ) dut (
      .aclk(aclk), .areset_n(areset_n),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout t=%0t", name, $time);
   endtask

   // ---------------- behavioural model / scoreboard ----------------
   logic [31:0] mem [NUM_REGS];
   logic [1:0]  exp_b_q[$];
   logic [33:0] exp_r_q[$];     // {rresp, rdata}
   bit          m_live;
   bit          m_aw_have, m_w_have;
   logic [31:0] m_aw_addr, m_w_data;
   logic [3:0]  m_w_strb;

   function automatic bit m_hit(input logic [31:0] a);
      longint unsigned la = a;
      return (la >= BASE) && (la < longint'(BASE) + 4 * NUM_REGS);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [33:0] model_read(input logic [31:0] a);
      if (!m_hit(a)) return {2'b10, 32'h0};
`ifdef AXIL_RO_ID_REG_EN
      if (m_idx(a) == NUM_REGS - 1) return {2'b00, 32'hA11E_0001};
`endif
      return {2'b00, mem[m_idx(a)]};
   endfunction

   function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
      if (!m_hit(a)) return 2'b10;
`ifdef AXIL_RO_ID_REG_EN
      if (m_idx(a) == NUM_REGS - 1) return 2'b10;
`endif
      for (int b = 0; b < 4; b++)
         if (s[b]) mem[m_idx(a)][8*b +: 8] = d[8*b +: 8];
      return 2'b00;
   endfunction

   // Compare process: at each falling edge check all outputs, then advance
   // the model to what the coming rising edge must do.
   bit exp_aw, exp_w, exp_ar, aw_f, w_f, ar_f;
   logic [33:0] rd_pre;

   always @(negedge aclk) begin
      if (!areset_n) begin
         chk("rst_awready", awready, 0);
         chk("rst_wready",  wready,  0);
         chk("rst_arready", arready, 0);
         chk("rst_bvalid",  bvalid,  0);
         chk("rst_bresp",   bresp,   0);
         chk("rst_rvalid",  rvalid,  0);
         chk("rst_rdata",   rdata,   0);
         chk("rst_rresp",   rresp,   0);
         for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
         exp_b_q.delete();
         exp_r_q.delete();
         m_live    = 0;
         m_aw_have = 0;
         m_w_have  = 0;
      end else begin
         exp_aw = m_live && exp_b_q.size() == 0 && !m_aw_have;
         exp_w  = m_live && exp_b_q.size() == 0 && !m_w_have;
         exp_ar = m_live && exp_r_q.size() == 0;
         chk("awready", awready, exp_aw);
         chk("wready",  wready,  exp_w);
         chk("arready", arready, exp_ar);
         chk("bvalid",  bvalid,  exp_b_q.size() != 0);
         if (exp_b_q.size() != 0) chk("bresp", bresp, exp_b_q[0]);
         chk("rvalid",  rvalid,  exp_r_q.size() != 0);
         if (exp_r_q.size() != 0) begin
            chk("rdata", rdata, exp_r_q[0][31:0]);
            chk("rresp", rresp, exp_r_q[0][33:32]);
         end
         aw_f = awvalid && exp_aw;
         w_f  = wvalid && exp_w;
         ar_f = arvalid && exp_ar;
         if (exp_b_q.size() != 0 && bready) void'(exp_b_q.pop_front());
         if (exp_r_q.size() != 0 && rready) void'(exp_r_q.pop_front());
         rd_pre = model_read(araddr);          // read sees pre-write bank
         if (aw_f) begin m_aw_have = 1; m_aw_addr = awaddr; end
         if (w_f)  begin m_w_have = 1; m_w_data = wdata; m_w_strb = wstrb; end
         if (m_aw_have && m_w_have) begin
            exp_b_q.push_back(model_write(m_aw_addr, m_w_data, m_w_strb));
            m_aw_have = 0;
            m_w_have  = 0;
         end
         if (ar_f) exp_r_q.push_back(rd_pre);
         m_live = 1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, output logic [1:0] resp);
      int n;
      bready = (b_dly == 0);
      fork
         begin
            int k;
            repeat (aw_dly) @(posedge aclk);
            #1 awaddr = addr; awvalid = 1'b1;
            k = 0;
            do begin @(negedge aclk); k++; end while (!awready && k < 100);
            if (!awready) timeout("aw_handshake");
            @(posedge aclk); #1 awvalid = 1'b0;
         end
         begin
            int k;
            repeat (w_dly) @(posedge aclk);
            #1 wdata = data; wstrb = strb; wvalid = 1'b1;
            k = 0;
            do begin @(negedge aclk); k++; end while (!wready && k < 100);
            if (!wready) timeout("w_handshake");
            @(posedge aclk); #1 wvalid = 1'b0;
         end
      join
      if (b_dly > 0) begin
         n = 0;
         do begin @(negedge aclk); n++; end while (!bvalid && n < 100);
         repeat (b_dly) @(posedge aclk);
         #1 bready = 1'b1;
      end
      n = 0;
      do begin @(negedge aclk); n++; end while (!bvalid && n < 100);
      if (!bvalid) timeout("b_handshake");
      resp = bresp;
      @(posedge aclk); #1 bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
      int n;
      rready = (r_dly == 0);
      repeat (ar_dly) @(posedge aclk);
      #1 araddr = addr; arvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!arready && n < 100);
      if (!arready) timeout("ar_handshake");
      @(posedge aclk); #1 arvalid = 1'b0;
      if (r_dly > 0) begin
         n = 0;
         do begin @(negedge aclk); n++; end while (!rvalid && n < 100);
         repeat (r_dly) @(posedge aclk);
         #1 rready = 1'b1;
      end
      n = 0;
      do begin @(negedge aclk); n++; end while (!rvalid && n < 100);
      if (!rvalid) timeout("r_handshake");
      data = rdata;
      resp = rresp;
      @(posedge aclk); #1 rready = 1'b0;
   endtask

   task automatic read_expect(input logic [31:0] addr, input logic [31:0] exp_d,
                              input logic [1:0] exp_r, input string name);
      logic [31:0] d;
      logic [1:0]  r;
      do_read(addr, 0, 0, d, r);
      chk({name, "_data"}, d, exp_d);
      chk({name, "_resp"}, r, exp_r);
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return 32'h40 + $urandom_range(0, 255);
      return BASE + 32'($urandom_range(0, NUM_REGS - 1)) * 4 + 32'($urandom_range(0, 3));
   endfunction

   // ---------------- main sequence ----------------
   logic [31:0] rd_d, wr_d;
   logic [1:0]  wr_r, rd_r;
   logic [31:0] id_val, last_val;

   initial begin
`ifdef AXIL_RO_ID_REG_EN
      id_val = 32'hA11E_0001;
`else
      id_val = 32'h0;
`endif
      areset_n = 1'b0;
      awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
      bready = 0; araddr = '0; arvalid = 0; rready = 0;
      repeat (3) @(posedge aclk);
      #1 areset_n = 1'b1;
      @(posedge aclk); #1;

      // AW+W together, bready high: minimum latency path.
      do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, wr_r);
      chk("wr04_bresp", wr_r, 2'b00);
      read_expect(32'h04, 32'hDEAD_BEEF, 2'b00, "rd04");

      // W three cycles ahead of AW.
      do_write(32'h08, 32'h1234_5678, 4'hF, 3, 0, 0, wr_r);
      chk("wr08_bresp", wr_r, 2'b00);
      read_expect(32'h08, 32'h1234_5678, 2'b00, "rd08");

      // Partial strobes.
      do_write(32'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, wr_r);
      do_write(32'h0C, 32'h0000_0000, 4'b0101, 1, 0, 0, wr_r);
      chk("wr0c_bresp", wr_r, 2'b00);
      read_expect(32'h0C, 32'hFF00_FF00, 2'b00, "rd0c");

      // wstrb=0 hit: OKAY, no change.
      do_write(32'h04, 32'h0, 4'h0, 0, 0, 0, wr_r);
      chk("wrstrb0_bresp", wr_r, 2'b00);
      read_expect(32'h04, 32'hDEAD_BEEF, 2'b00, "rdstrb0");

      // Out of range: SLVERR both ways, bank unchanged.
      do_write(32'h40, 32'h5555_5555, 4'hF, 0, 1, 0, wr_r);
      chk("wr40_bresp", wr_r, 2'b10);
      read_expect(32'h40, 32'h0, 2'b10, "rd40");
      for (int i = 0; i < NUM_REGS; i++) begin
         case (i)
            1:       last_val = 32'hDEAD_BEEF;
            2:       last_val = 32'h1234_5678;
            3:       last_val = 32'hFF00_FF00;
            15:      last_val = id_val;
            default: last_val = 32'h0;
         endcase
         read_expect(BASE + 32'(i) * 4, last_val, 2'b00, $sformatf("bank%0d", i));
      end

      // Back-pressure on B and R for 5 cycles, both channels concurrently.
      fork
         do_write(32'h14, 32'hAAAA_5555, 4'hF, 0, 0, 5, wr_r);
         do_read(32'h04, 0, 5, rd_d, rd_r);
      join
      chk("stall_bresp", wr_r, 2'b00);
      chk("stall_rdata", rd_d, 32'hDEAD_BEEF);

      // Same-edge read and write of one register: read sees the old value.
      do_write(32'h10, 32'h1111_1111, 4'hF, 0, 0, 0, wr_r);
      fork
         do_write(32'h10, 32'h2222_2222, 4'hF, 0, 0, 0, wr_r);
         do_read(32'h10, 0, 0, rd_d, rd_r);
      join
      chk("same_edge_rdata", rd_d, 32'h1111_1111);
      read_expect(32'h10, 32'h2222_2222, 2'b00, "after_same_edge");

      // Randomized traffic checked by the model each cycle.
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 2))
            0: do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), wr_r);
            1: do_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3), rd_d, rd_r);
            default: fork
               do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), wr_r);
               do_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3), rd_d, rd_r);
            join
         endcase
      end

      // Reset while a write response is pending.
      @(posedge aclk); #1;
      awaddr = 32'h08; wdata = 32'h7777_7777; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge aclk);
      chk("pre_rst_awready", awready, 1);
      @(posedge aclk); #1 awvalid = 1'b0; wvalid = 1'b0;
      @(negedge aclk);
      chk("pre_rst_bvalid", bvalid, 1);
      #2 areset_n = 1'b0;
      #1 chk("rst_async_bvalid", bvalid, 0);
      chk("rst_async_awready", awready, 0);
      repeat (2) @(posedge aclk);
      #1 areset_n = 1'b1;
      @(posedge aclk); #1;
      for (int i = 0; i < NUM_REGS; i++)
         read_expect(BASE + 32'(i) * 4, (i == NUM_REGS - 1) ? id_val : 32'h0, 2'b00,
                     $sformatf("post_rst%0d", i));

      // Top register: read-only ID when enabled, ordinary otherwise.
      do_write(32'h3C, 32'hCAFE_F00D, 4'hF, 0, 0, 0, wr_r);
`ifdef AXIL_RO_ID_REG_EN
      chk("ro_bresp", wr_r, 2'b10);
      read_expect(32'h3C, 32'hA11E_0001, 2'b00, "ro_read");
`else
      chk("rw3c_bresp", wr_r, 2'b00);
      read_expect(32'h3C, 32'hCAFE_F00D, 2'b00, "rw3c_read");
`endif
      wr_d = 32'h0;
      repeat (3) @(posedge aclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors + int'(wr_d));
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog run did not complete t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
